prefix_subtractor_pipe: RTL and testbench
=========================================

// Module: prefix_subtractor_pipe
// PURPOSE
//   Pipelined parallel-prefix subtractor, the inverse-direction companion of the
//   team's 6-bit prefix adder: computes d = x - y as x + ~y + 1.
//   A Kogge-Stone carry network computes the carries.
//   Two registered stages with valid/ready handshakes on both sides, so the
//   block sits directly in a streaming ALU datapath and absorbs back-pressure.
// PARAMETERS
//   WIDTH   6   operand/result width in bits; legal range 2..16
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      reset; synchronous, active-low
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands this cycle
//   x          in   WIDTH  minuend, unsigned or two's complement
//   y          in   WIDTH  subtrahend
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result this cycle
//   d          out  WIDTH  difference, (x - y) mod 2^WIDTH
//   bw         out  1      unsigned borrow: 1 iff x < y unsigned
//   ov         out  1      signed overflow: x[W-1] != y[W-1] && d[W-1] != x[W-1]
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): out_valid=0, d=0, bw=0, ov=0, both stage
//     valid bits 0. in_ready is 0 while rst_n=0 and 1 on the first cycle after.
//     Reset mid-operation drops all in-flight results; none reappear later.
//   - Transfer rules:
//     - Input transfer when in_valid && in_ready.
//     - Output transfer when out_valid && out_ready.
//     - x and y are sampled only on input transfer.
//     - d, bw, ov hold stable while out_valid && !out_ready.
//   - Stage 1 (S1) registers, per bit:
//     - g_i = x_i & ~y_i
//     - p_i = x_i ^ ~y_i
//     - stage valid bit v1
//     - carry-in c0 = 1 is folded in as bit -1 (g = 1).
//   - Stage 2 (S2) registers:
//     - d_i = p_i ^ c_i, with c_i from the prefix tree over (g,p) pairs
//     - bw = ~c_WIDTH
//     - ov as defined in PORTS
//     - stage valid bit v2
//   - Pipeline advance:
//     - adv2 = !v2 || out_ready
//     - adv1 = !v1 || adv2
//     - in_ready = adv1 (combinational from out_ready and the valid bits).
//   - Latency: exactly 2 cycles from input transfer to out_valid when
//     out_ready stays 1. Throughput is 1 result per cycle.
//   - Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts
//     the new input, shifts S1 to S2 and emits S2 in the same cycle. No bubble
//     and no loss.
//   - Stall: out_ready=0 with v1=v2=1 gives in_ready=0, and both stages hold.
//     Results leave in strict input order and are never duplicated.
//   - Wrap-around: the result is modulo 2^WIDTH, e.g. 0 - 1 = all ones, bw=1.
//     y=0 gives bw=0 and d=x.
// STRUCTURE
//   - Shared package alu_pkg:
//     - ALU_WIDTH = 6
//     - gp_t = struct {g, p}
//     - function gp_combine(hi, lo) = {hi.g | hi.p & lo.g, hi.p & lo.p}.
//     The adder reuses the same package.
//   - Sub-module prefix_gp_tree:
//     - combinational, parameter WIDTH
//     - inputs g/p vectors and cin; output carries c[WIDTH:1]
//     - log2 levels of gp_combine
//   - Top level holds only the stage registers, handshake logic and
//     result/flag formation.
// TESTING
//   - After reset: out_valid=0, d=0, bw=0, ov=0; first cycle after reset
//     in_ready=1.
//   - x=5, y=3, out_ready=1: out_valid two cycles later with d=2, bw=0, ov=0.
//     Then x=3, y=5 gives d=62, bw=1, ov=0.
//   - Boundaries:
//     - x=0, y=1 -> d=63, bw=1, ov=0
//     - x=32, y=1 -> d=31, bw=0, ov=1
//     - x=31, y=63 -> d=32, bw=1, ov=1
//     - x=63, y=0 -> d=63, bw=0
//   - Exhaustive 64x64 pairs streamed back-to-back with out_ready=1:
//     4096 results in order, each matching {bw,d} = {x<y, (x-y)&63}; 0 errors.
//   - Back-pressure: stream 10 pairs while out_ready=0 for cycles 3-8.
//     in_ready drops after 2 accepts; d holds stable; all 10 arrive in order,
//     none dropped or duplicated.
//   - Reset mid-stream with v1=v2=1: after reset, out_valid=0 and no stale
//     result is ever emitted. The next pair x=7, y=7 returns d=0, bw=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: generate/propagate pairs and their prefix operator.
// Used by both the prefix adder and the prefix subtractor.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(
    gp_t hi,
    gp_t lo
  );
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/prefix_subtractor_pipe_if.sv
// Operand/result stream bundle for the pipelined prefix subtractor.
// master drives operands and accepts results; slave is the block.
interface prefix_subtractor_pipe_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bw;
  logic             ov;

  modport master (
    output in_valid,
    input  in_ready,
    output x,
    output y,
    input  out_valid,
    output out_ready,
    input  d,
    input  bw,
    input  ov
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  x,
    input  y,
    output out_valid,
    input  out_ready,
    output d,
    output bw,
    output ov
  );

endinterface

// File: rtl/prefix_gp_tree.sv
// Kogge-Stone carry network: carries c[WIDTH:1] from per-bit g/p and cin.
// cin enters as an extra lowest position with g=cin, p=0.
module prefix_gp_tree
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic [WIDTH:1]   c
);

  localparam int N      = WIDTH + 1;
  localparam int LEVELS = $clog2(N);

  always_comb begin
    gp_t lvl [N];
    gp_t nxt [N];
    lvl[0].g = cin;
    lvl[0].p = 1'b0;
    for (int k = 1; k < N; k++) begin
      lvl[k].g = g[k-1];
      lvl[k].p = p[k-1];
    end
    nxt = lvl;
    for (int l = 0; l < LEVELS; l++) begin
      for (int k = 0; k < N; k++) begin
        if (k >= (1 << l)) begin
          nxt[k] = gp_combine(lvl[k], lvl[k-(1<<l)]);
        end else begin
          nxt[k] = lvl[k];
        end
      end
      lvl = nxt;
    end
    c = '0;
    for (int k = 1; k < N; k++) begin
      c[k] = lvl[k].g;
    end
  end

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage valid/ready pipelined subtractor d = x + ~y + 1.
// S1 holds g/p, S2 holds difference and borrow/overflow flags.
module prefix_subtractor_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  prefix_subtractor_pipe_if.slave io
);

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic             xm1_q, xm1_d;
  logic             ym1_q, ym1_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bw_q, bw_d;
  logic             ov_q, ov_d;
  logic [WIDTH:1]   c;
  logic             adv1, adv2;

  assign adv2 = !v2_q || io.out_ready;
  assign adv1 = !v1_q || adv2;
  assign io.in_ready = rst_n && adv1;

  always_comb begin
    v1_d  = v1_q;
    g1_d  = g1_q;
    p1_d  = p1_q;
    xm1_d = xm1_q;
    ym1_d = ym1_q;
    if (adv1) begin
      v1_d = io.in_valid;
      if (io.in_valid) begin
        g1_d  = io.x & ~io.y;
        p1_d  = io.x ^ ~io.y;
        xm1_d = io.x[WIDTH-1];
        ym1_d = io.y[WIDTH-1];
      end
    end
  end

  prefix_gp_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .g  (g1_q),
    .p  (p1_q),
    .cin(1'b1),
    .c  (c)
  );

  // c[0] is the folded-in +1 of the two's-complement negate
  always_comb begin
    v2_d = v2_q;
    d_d  = d_q;
    bw_d = bw_q;
    ov_d = ov_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        d_d  = p1_q ^ {c[WIDTH-1:1], 1'b1};
        bw_d = ~c[WIDTH];
        ov_d = (xm1_q != ym1_q) &&
               (d_d[WIDTH-1] != xm1_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      g1_q  <= '0;
      p1_q  <= '0;
      xm1_q <= 1'b0;
      ym1_q <= 1'b0;
      d_q   <= '0;
      bw_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      g1_q  <= g1_d;
      p1_q  <= p1_d;
      xm1_q <= xm1_d;
      ym1_q <= ym1_d;
      d_q   <= d_d;
      bw_q  <= bw_d;
      ov_q  <= ov_d;
    end
  end

  assign io.out_valid = v2_q;
  assign io.d         = d_q;
  assign io.bw        = bw_q;
  assign io.ov        = ov_q;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe: arithmetic model, in-order scoreboard,
// directed boundaries, exhaustive sweep, back-pressure and reset cases.
module tb_prefix_subtractor_pipe;

  localparam int W = 6;

  typedef struct {
    int d;
    int bw;
    int ov;
  } res_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n_in;
  int   n_out;
  bit   rnd_rdy;
  bit   hold;
  res_t hexp;
  res_t exp_q[$];

  prefix_subtractor_pipe_if #(.WIDTH(W)) io ();

  prefix_subtractor_pipe #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(int xi, int yi);
    res_t r;
    int sx, sy, sd;
    sx = (xi >= 32) ? xi - 64 : xi;
    sy = (yi >= 32) ? yi - 64 : yi;
    sd = sx - sy;
    r.d  = ((xi - yi) % 64 + 64) % 64;
    r.bw = (xi < yi) ? 1 : 0;
    r.ov = (sd > 31 || sd < -32) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // scoreboard: transfers decided by values stable across the negedge
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", int'(io.out_valid), 1);
        chk("hold_d", int'(io.d), hexp.d);
        chk("hold_bw", int'(io.bw), hexp.bw);
        chk("hold_ov", int'(io.ov), hexp.ov);
      end
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", int'(io.out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_d", int'(io.d), e.d);
          chk("sb_bw", int'(io.bw), e.bw);
          chk("sb_ov", int'(io.ov), e.ov);
          n_out++;
        end
      end
      hold   = io.out_valid && !io.out_ready;
      hexp.d  = int'(io.d);
      hexp.bw = int'(io.bw);
      hexp.ov = int'(io.ov);
      if (io.in_valid && io.in_ready) begin
        exp_q.push_back(model(int'(io.x), int'(io.y)));
        n_in++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) io.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send(int xi, int yi);
    int guard;
    guard = 0;
    io.in_valid = 1'b1;
    io.x = W'(xi);
    io.y = W'(yi);
    @(negedge clk);
    while (!io.in_ready) begin
      guard++;
      if (guard > 200) begin
        chk("send_timeout", int'(io.in_ready), 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic dir(int xi, int yi, int ed, int eb, int eo,
                     string nm);
    @(posedge clk);
    #1;
    io.in_valid = 1'b1;
    io.x = W'(xi);
    io.y = W'(yi);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, int'(io.out_valid), 0);
    @(negedge clk);
    chk({nm, "_valid"}, int'(io.out_valid), 1);
    chk({nm, "_d"}, int'(io.d), ed);
    chk({nm, "_bw"}, int'(io.bw), eb);
    chk({nm, "_ov"}, int'(io.ov), eo);
  endtask

  task automatic drain();
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_count", n_out, n_in);
  endtask

  initial begin
    res_t m;
    int   acc;
    total = 0;
    bad = 0;
    n_in = 0;
    n_out = 0;
    rnd_rdy = 0;
    hold = 0;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.x = '0;
    io.y = '0;
    io.out_ready = 1'b1;

    m = model(3, 5);
    chk("model_3_5", m.d * 4 + m.bw * 2 + m.ov, 62 * 4 + 2);
    m = model(32, 1);
    chk("model_32_1", m.d * 4 + m.bw * 2 + m.ov, 31 * 4 + 1);
    m = model(31, 63);
    chk("model_31_63", m.d * 4 + m.bw * 2 + m.ov, 32 * 4 + 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_d", int'(io.d), 0);
    chk("rst_bw", int'(io.bw), 0);
    chk("rst_ov", int'(io.ov), 0);
    chk("rst_in_ready", int'(io.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(io.in_ready), 1);
    chk("post_rst_valid", int'(io.out_valid), 0);

    dir(5, 3, 2, 0, 0, "d5_3");
    dir(3, 5, 62, 1, 0, "d3_5");
    dir(0, 1, 63, 1, 0, "d0_1");
    dir(32, 1, 31, 0, 1, "d32_1");
    dir(31, 63, 32, 1, 1, "d31_63");
    dir(63, 0, 63, 0, 0, "d63_0");
    drain();

    for (int xi = 0; xi < 64; xi++) begin
      for (int yi = 0; yi < 64; yi++) begin
        send(xi, yi);
      end
    end
    drain();

    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
    end
    rnd_rdy = 0;
    @(posedge clk);
    drain();

    // stalled output: only two operand pairs fit
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.x = W'(9);
    io.y = W'(4);
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      if (io.in_valid && io.in_ready) acc++;
    end
    chk("stall_accepts", acc, 2);
    chk("stall_in_ready", int'(io.in_ready), 0);
    @(posedge clk);
    #1;
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)));
        end
      end
      begin
        for (int cyc = 0; cyc < 12; cyc++) begin
          io.out_ready = !(cyc >= 3 && cyc <= 8);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    chk("bp_total", n_in, 4096 + 6 + 400 + 2 + 10);

    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    send(17, 40);
    send(50, 2);
    @(negedge clk);
    chk("full_in_ready", int'(io.in_ready), 0);
    chk("full_out_valid", int'(io.out_valid), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("mid_rst_valid", int'(io.out_valid), 0);
    end
    dir(7, 7, 0, 0, 0, "d7_7");
    repeat (6) @(posedge clk);
    #1;
    chk("end_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
